// File: rtl/serial_digit_subtractor.sv
// Digit-serial subtractor: computes a - b (or 0 - b) one DIGIT-bit digit per clock,
// least-significant digit first, with a chained borrow register and start/done handshake.
module serial_digit_subtractor #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic             bout,
   output logic             zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  a_r, b_r;
   logic [IDXW-1:0]   idx;
   logic              borrow;
   logic [DIGIT:0]    dfull;
   logic [WIDTH-1:0]  y_nx;
   logic              last;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
   end

   // One digit of the difference; the extra MSB of dfull is the borrow out.
   always_comb begin
      dfull = {1'b0, a_r[idx*DIGIT +: DIGIT]} - {1'b0, b_r[idx*DIGIT +: DIGIT]}
              - {{DIGIT{1'b0}}, borrow};
      y_nx  = y;
      y_nx[idx*DIGIT +: DIGIT] = dfull[DIGIT-1:0];
      last  = (idx == IDXW'(NDIG - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         idx    <= '0;
         borrow <= 1'b0;
         y      <= '0;
         bout   <= 1'b0;
         zero   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_r    <= mode ? '0 : a;
                  b_r    <= b;
                  borrow <= 1'b0;
                  idx    <= '0;
                  y      <= '0;
               end
            end
            RUN: begin
               y      <= y_nx;
               borrow <= dfull[DIGIT];
               idx    <= last ? '0 : idx + 1'b1;
               if (last) begin
                  bout <= dfull[DIGIT];
                  zero <= (y_nx == '0);
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_digit_subtractor.sv
// Self-checking bench for serial_digit_subtractor: default 32/8 instance plus 16/4 and 8/8 variants.
module tb_serial_digit_subtractor;

   typedef struct {
      logic        m;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        bo;
      logic        z;
   } vec_t;

   typedef struct {
      logic [31:0] y;
      logic        bo;
      logic        z;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        start = 1'b0, mode = 1'b0;
   logic [31:0] a = '0, b = '0, y;
   logic        busy, done, bout, zero;

   logic        s16_start = 1'b0, s16_mode = 1'b0;
   logic [15:0] s16_a = '0, s16_b = '0, s16_y;
   logic        s16_busy, s16_done, s16_bout, s16_zero;

   logic        s8_start = 1'b0, s8_mode = 1'b0;
   logic [7:0]  s8_a = '0, s8_b = '0, s8_y;
   logic        s8_busy, s8_done, s8_bout, s8_zero;

   int   passed = 0;
   int   total  = 0;
   logic last_bout = 1'b0;
   exp_t sb[$];
   vec_t vecs[8];

   always #5 clk = ~clk;

   serial_digit_subtractor #(.WIDTH(32), .DIGIT(8)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
      .busy(busy), .done(done), .y(y), .bout(bout), .zero(zero));

   serial_digit_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst(rst), .start(s16_start), .mode(s16_mode), .a(s16_a), .b(s16_b),
      .busy(s16_busy), .done(s16_done), .y(s16_y), .bout(s16_bout), .zero(s16_zero));

   serial_digit_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
      .clk(clk), .rst(rst), .start(s8_start), .mode(s8_mode), .a(s8_a), .b(s8_b),
      .busy(s8_busy), .done(s8_done), .y(s8_y), .bout(s8_bout), .zero(s8_zero));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic pop_cmp(input string tag, input logic [31:0] gy, input logic gb, input logic gz);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL %s: got done with empty scoreboard expected none", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, " y"}, gy, e.y);
         chk({tag, " bout"}, {31'b0, gb}, {31'b0, e.bo});
         chk({tag, " zero"}, {31'b0, gz}, {31'b0, e.z});
      end
   endtask

   task automatic do_op(input string tag, input logic m, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ey, input logic eb, input logic ez);
      int cyc;
      mode = m; a = av; b = bv; start = 1'b1;
      sb.push_back('{ey, eb, ez});
      tick();
      start = 1'b0; a = ~av; b = ~bv; mode = ~m;
      chk({tag, " busy"}, {31'b0, busy}, 32'd1);
      chk({tag, " y cleared"}, y, 32'h0);
      chk({tag, " bout held"}, {31'b0, bout}, {31'b0, last_bout});
      cyc = 0;
      while (!done && cyc < 20) begin tick(); cyc++; end
      chk({tag, " latency"}, cyc, 32'd4);
      pop_cmp(tag, y, bout, zero);
      last_bout = eb;
      tick();
      chk({tag, " done low"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      int dt[$];
      int cyc;
      logic        rm;
      logic [31:0] ra, rb, rea;

      vecs[0] = '{1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 32'h12345678, 32'h02030405, 32'h10315273, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 32'hDEADBEEF, 32'h00000005, 32'hFFFFFFFB, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0};

      tick(); tick();
      rst = 1'b0;
      chk("reset busy", {31'b0, busy}, 32'd0);
      chk("reset done", {31'b0, done}, 32'd0);
      chk("reset y", y, 32'h0);
      chk("reset bout", {31'b0, bout}, 32'd0);
      chk("reset zero", {31'b0, zero}, 32'd0);

      for (int i = 0; i < 8; i++)
         do_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].bo, vecs[i].z);

      for (int i = 0; i < 6; i++) begin
         rm = 1'($urandom_range(0, 1)); ra = $urandom; rb = $urandom;
         rea = rm ? 32'h0 : ra;
         do_op($sformatf("rand%0d", i), rm, ra, rb, rea - rb, rea < rb, (rea - rb) == 32'h0);
      end

      // Start while busy is ignored; intermediate y shows only digit 0.
      mode = 1'b0; a = 32'h12345678; b = 32'h02030405; start = 1'b1;
      sb.push_back('{32'h10315273, 1'b0, 1'b0});
      tick();
      start = 1'b0;
      tick();
      chk("partial y", y, 32'h00000073);
      start = 1'b1; a = 32'h00000000; b = 32'h00000001;
      tick();
      start = 1'b0;
      tick();
      chk("busy ignore done early", {31'b0, done}, 32'd0);
      tick();
      chk("busy ignore done", {31'b0, done}, 32'd1);
      pop_cmp("busy ignore", y, bout, zero);
      tick();
      chk("busy ignore no queue", {31'b0, busy}, 32'd0);
      last_bout = 1'b0;

      // Start held high: done every NDIG+1 cycles.
      mode = 1'b0; a = 32'h00000100; b = 32'h00000001; start = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back('{32'h000000FF, 1'b0, 1'b0});
      tick();
      for (int t = 1; t <= 14; t++) begin
         tick();
         if (done) begin
            dt.push_back(t);
            pop_cmp($sformatf("held%0d", t), y, bout, zero);
         end
      end
      start = 1'b0;
      chk("held done count", dt.size(), 32'd3);
      if (dt.size() == 3) begin
         chk("held first", dt[0], 32'd4);
         chk("held gap1", dt[1] - dt[0], 32'd5);
         chk("held gap2", dt[2] - dt[1], 32'd5);
      end
      tick();
      tick();
      chk("held idle", {31'b0, busy}, 32'd0);

      // Mid-operation reset after an op leaving bout=1.
      do_op("pre rst", 1'b0, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b1, 1'b0);
      mode = 1'b0; a = 32'h12345678; b = 32'h02030405; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort busy", {31'b0, busy}, 32'd0);
      chk("abort done", {31'b0, done}, 32'd0);
      chk("abort y", y, 32'h0);
      chk("abort bout", {31'b0, bout}, 32'd0);
      chk("abort zero", {31'b0, zero}, 32'd0);
      tick();
      chk("abort no done", {31'b0, done}, 32'd0);
      last_bout = 1'b0;
      do_op("post rst", 1'b0, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0);

      // WIDTH=16, DIGIT=4.
      s16_mode = 1'b0; s16_a = 16'h1000; s16_b = 16'h0001; s16_start = 1'b1;
      sb.push_back('{32'h00000FFF, 1'b0, 1'b0});
      tick();
      s16_start = 1'b0;
      cyc = 0;
      while (!s16_done && cyc < 20) begin tick(); cyc++; end
      chk("w16 latency", cyc, 32'd4);
      pop_cmp("w16", {16'h0, s16_y}, s16_bout, s16_zero);
      tick();
      s16_mode = 1'b1; s16_a = 16'h5555; s16_b = 16'h0001; s16_start = 1'b1;
      sb.push_back('{32'h0000FFFF, 1'b1, 1'b0});
      tick();
      s16_start = 1'b0;
      cyc = 0;
      while (!s16_done && cyc < 20) begin tick(); cyc++; end
      chk("w16 neg latency", cyc, 32'd4);
      pop_cmp("w16 neg", {16'h0, s16_y}, s16_bout, s16_zero);

      // WIDTH=8, DIGIT=8: single RUN cycle.
      s8_mode = 1'b0; s8_a = 8'h03; s8_b = 8'h05; s8_start = 1'b1;
      sb.push_back('{32'h000000FE, 1'b1, 1'b0});
      tick();
      s8_start = 1'b0;
      cyc = 0;
      while (!s8_done && cyc < 20) begin tick(); cyc++; end
      chk("w8 latency", cyc, 32'd1);
      pop_cmp("w8", {24'h0, s8_y}, s8_bout, s8_zero);
      s8_a = 8'h05; s8_b = 8'h03; s8_start = 1'b1;
      sb.push_back('{32'h00000002, 1'b0, 1'b0});
      tick();
      s8_start = 1'b0;
      cyc = 0;
      while (!s8_done && cyc < 20) begin tick(); cyc++; end
      chk("w8b latency", cyc, 32'd1);
      pop_cmp("w8b", {24'h0, s8_y}, s8_bout, s8_zero);

      chk("scoreboard drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
